// File: rtl/execute_unit_sched_pkg.sv
// execute_unit_sched_pkg: shared types and constants for the execute-stage scheduler.
package execute_unit_sched_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} sched_state_t;
    localparam int UNIT_SHIFT         = 0;
    localparam int UNIT_MULDIV        = 1;
    localparam int DEF_TIMEOUT_CYCLES = 15;
endpackage

// File: rtl/execute_sched_watchdog.sv
// execute_sched_watchdog: saturating busy-cycle counter; expire fires on the cycle the count would reach the limit.
module execute_sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] r_cnt;
    assign o_expire = i_en && (r_cnt == W'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && r_cnt != W'(TIMEOUT_CYCLES))
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/execute_unit_sched.sv
// execute_unit_sched: issues one op at a time to a multi-cycle unit, holds its result for writeback,
// and aborts ops whose unit never completes.
module execute_unit_sched
    import execute_unit_sched_pkg::*;
#(
    parameter int N_UNITS        = 2,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [N_UNITS-1:0]      in_unit_sel,
    input  logic [4:0]              in_rd,
    output logic                    in_ready,
    output logic [N_UNITS-1:0]      unit_start,
    output logic                    unit_flush,
    input  logic [N_UNITS-1:0]      unit_valid,
    input  logic [N_UNITS*XLEN-1:0] unit_rd_val,
    output logic                    wb_valid,
    output logic [4:0]              wb_rd,
    output logic [XLEN-1:0]         wb_val,
    input  logic                    wb_ready,
    output logic                    err_timeout,
    output logic                    err_bad_sel
);
    sched_state_t       r_state;
    logic [N_UNITS-1:0] r_sel;
    logic [4:0]         r_rd;
    logic [4:0]         r_wb_rd;
    logic [XLEN-1:0]    r_wb_val;
    logic               r_err_timeout;
    logic               r_err_bad_sel;
    logic               w_busy;
    logic [N_UNITS-1:0] w_pick;
    logic               w_hit;
    logic [XLEN-1:0]    w_res;
    logic               w_sel_ok;
    logic               w_accept;
    logic               w_start_ok;
    logic               w_wd_en;
    logic               w_expire;
    logic               w_abort;

    // In BUSY only the latched unit is watched; otherwise the incoming select picks the same-cycle result.
    assign w_busy     = (r_state == BUSY);
    assign w_pick     = w_busy ? r_sel : in_unit_sel;
    assign w_hit      = |(unit_valid & w_pick);
    assign w_sel_ok   = $onehot(in_unit_sel);
    assign in_ready   = !reset && !flush && (r_state == IDLE || (r_state == HOLD && wb_ready));
    assign w_accept   = in_valid && in_ready;
    assign w_start_ok = w_accept && w_sel_ok;
    assign unit_start = w_start_ok ? in_unit_sel : '0;
    assign w_wd_en    = w_busy && !w_hit && !flush;
    assign w_abort    = w_wd_en && w_expire;
    assign unit_flush = flush || w_abort;
    assign wb_valid    = (r_state == HOLD);
    assign wb_rd       = r_wb_rd;
    assign wb_val      = r_wb_val;
    assign err_timeout = r_err_timeout;
    assign err_bad_sel = r_err_bad_sel;

    always_comb begin
        w_res = '0;
        for (int i = 0; i < N_UNITS; i++)
            if (w_pick[i])
                w_res = w_res | unit_rd_val[i*XLEN +: XLEN];
    end

    execute_sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_start_ok),
        .i_en     (w_wd_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_sel         <= '0;
            r_rd          <= '0;
            r_wb_rd       <= '0;
            r_wb_val      <= '0;
            r_err_timeout <= 1'b0;
            r_err_bad_sel <= 1'b0;
        end else begin
            r_err_timeout <= w_abort;
            r_err_bad_sel <= w_accept && !w_sel_ok;
            if (flush) begin
                r_state <= IDLE;
            end else if (w_accept) begin
                if (!w_sel_ok) begin
                    r_state <= IDLE;
                end else begin
                    r_sel <= in_unit_sel;
                    r_rd  <= in_rd;
                    if (w_hit) begin
                        r_wb_val <= w_res;
                        r_wb_rd  <= in_rd;
                        r_state  <= HOLD;
                    end else begin
                        r_state <= BUSY;
                    end
                end
            end else if (w_busy && w_hit) begin
                r_wb_val <= w_res;
                r_wb_rd  <= r_rd;
                r_state  <= HOLD;
            end else if (w_abort) begin
                r_state <= IDLE;
            end else if (r_state == HOLD && wb_ready) begin
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_execute_unit_sched.sv
// tb_execute_unit_sched: directed vectors with hand-computed expectations; units are modelled by the bench.
module tb_execute_unit_sched;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, unit_flush, wb_valid, wb_ready;
    logic        err_timeout, err_bad_sel;
    logic [1:0]  in_unit_sel, unit_start, unit_valid;
    logic [4:0]  in_rd, wb_rd;
    logic [63:0] unit_rd_val;
    logic [31:0] wb_val;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    execute_unit_sched dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_unit_sel (in_unit_sel),
        .in_rd       (in_rd),
        .in_ready    (in_ready),
        .unit_start  (unit_start),
        .unit_flush  (unit_flush),
        .unit_valid  (unit_valid),
        .unit_rd_val (unit_rd_val),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_val      (wb_val),
        .wb_ready    (wb_ready),
        .err_timeout (err_timeout),
        .err_bad_sel (err_bad_sel)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd);
        in_valid    = 1'b1;
        in_unit_sel = sel;
        in_rd       = rd;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wb_ready = 1'b0;
        unit_valid = '0; unit_rd_val = '0;
        issue(2'b01, 5'd1);
        #12;
        chk("rst_start", 32'(unit_start), 32'h0);
        chk("rst_wbv", 32'(wb_valid), 32'h0);
        chk("rst_wbrd", 32'(wb_rd), 32'h0);
        chk("rst_wbval", wb_val, 32'h0);
        chk("rst_err", {30'h0, err_timeout, err_bad_sel}, 32'h0);
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        // shift by 3 completes in the start cycle
        issue(2'b01, 5'd5);
        unit_valid = 2'b01; unit_rd_val[31:0] = 32'h8;
        #1;
        chk("t1_ready", 32'(in_ready), 32'h1);
        chk("t1_start", 32'(unit_start), 32'h1);
        step();
        in_valid = 1'b0; unit_valid = '0;
        chk("t1_wbv", 32'(wb_valid), 32'h1);
        chk("t1_wbval", wb_val, 32'h8);
        chk("t1_wbrd", 32'(wb_rd), 32'd5);
        chk("t1_ready_hold", 32'(in_ready), 32'h0);
        step();
        chk("t1_wbv_held", 32'(wb_valid), 32'h1);
        wb_ready = 1'b1;
        #1;
        chk("t1_ready_wbr", 32'(in_ready), 32'h1);
        step();
        wb_ready = 1'b0;
        chk("t1_wbv_done", 32'(wb_valid), 32'h0);
        // SRA by 31: valid three cycles after start
        issue(2'b01, 5'd7);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk("t2_ready_busy", 32'(in_ready), 32'h0);
            chk("t2_wbv_busy", 32'(wb_valid), 32'h0);
            if (k == 3) begin
                unit_valid = 2'b01; unit_rd_val[31:0] = 32'hFFFF_FFFF;
            end
            step();
        end
        unit_valid = '0;
        chk("t2_wbv", 32'(wb_valid), 32'h1);
        chk("t2_wbval", wb_val, 32'hFFFF_FFFF);
        chk("t2_wbrd", 32'(wb_rd), 32'd7);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_stable_val", wb_val, 32'hFFFF_FFFF);
            chk("t3_stable_rd", 32'(wb_rd), 32'd7);
        end
        // back-to-back issue from HOLD
        issue(2'b10, 5'd9);
        wb_ready = 1'b1;
        #1;
        chk("t3_ready", 32'(in_ready), 32'h1);
        chk("t3_start", 32'(unit_start), 32'h2);
        step();
        in_valid = 1'b0; wb_ready = 1'b0;
        chk("t3_wbv_busy", 32'(wb_valid), 32'h0);
        unit_valid = 2'b01; unit_rd_val[31:0] = 32'h1234;
        step();
        chk("t3_other_ignored", 32'(wb_valid), 32'h0);
        unit_valid = 2'b10; unit_rd_val[63:32] = 32'hCAFE;
        step();
        unit_valid = '0;
        chk("t3_wbval", wb_val, 32'hCAFE);
        chk("t3_wbrd", 32'(wb_rd), 32'd9);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        // unit that never answers
        issue(2'b10, 5'd3);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            chk("t4_uflush", 32'(unit_flush), (k == 15) ? 32'h1 : 32'h0);
            chk("t4_terr_early", 32'(err_timeout), 32'h0);
            step();
        end
        chk("t4_terr", 32'(err_timeout), 32'h1);
        chk("t4_uflush_after", 32'(unit_flush), 32'h0);
        chk("t4_ready", 32'(in_ready), 32'h1);
        issue(2'b01, 5'd4);
        unit_valid = 2'b01; unit_rd_val[31:0] = 32'h55;
        step();
        in_valid = 1'b0; unit_valid = '0;
        chk("t4_terr_clear", 32'(err_timeout), 32'h0);
        chk("t4_next_wbv", 32'(wb_valid), 32'h1);
        chk("t4_next_val", wb_val, 32'h55);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        // flush in BUSY, late valid ignored
        issue(2'b01, 5'd6);
        step();
        flush = 1'b1;
        #1;
        chk("t5_uflush", 32'(unit_flush), 32'h1);
        chk("t5_ready", 32'(in_ready), 32'h0);
        chk("t5_start", 32'(unit_start), 32'h0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_wbv0", 32'(wb_valid), 32'h0);
        step();
        unit_valid = 2'b01; unit_rd_val[31:0] = 32'h77;
        step();
        unit_valid = '0;
        chk("t5_late_valid", 32'(wb_valid), 32'h0);
        chk("t5_ready_idle", 32'(in_ready), 32'h1);
        // flush in HOLD
        issue(2'b01, 5'd2);
        unit_valid = 2'b01;
        step();
        in_valid = 1'b0; unit_valid = '0;
        chk("t5_hold_wbv", 32'(wb_valid), 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_hold_flush", 32'(wb_valid), 32'h0);
        // bad selects
        issue(2'b00, 5'd1);
        #1;
        chk("t6_ready0", 32'(in_ready), 32'h1);
        chk("t6_start0", 32'(unit_start), 32'h0);
        step();
        chk("t6_bad0", 32'(err_bad_sel), 32'h1);
        chk("t6_wbv0", 32'(wb_valid), 32'h0);
        in_unit_sel = 2'b11;
        #1;
        chk("t6_start3", 32'(unit_start), 32'h0);
        step();
        in_valid = 1'b0;
        chk("t6_bad3", 32'(err_bad_sel), 32'h1);
        step();
        chk("t6_bad_clear", 32'(err_bad_sel), 32'h0);
        // async reset mid-BUSY and in HOLD
        issue(2'b01, 5'd8);
        step();
        in_valid = 1'b0;
        chk("t7_busy", 32'(in_ready), 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("t7_rst_wbv", 32'(wb_valid), 32'h0);
        chk("t7_rst_start", 32'(unit_start), 32'h0);
        reset = 1'b0;
        #1;
        chk("t7_idle_async", 32'(in_ready), 32'h1);
        issue(2'b01, 5'd8);
        unit_valid = 2'b01; unit_rd_val[31:0] = 32'h99;
        step();
        in_valid = 1'b0; unit_valid = '0;
        chk("t7_hold", 32'(wb_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t7_hold_rst_wbv", 32'(wb_valid), 32'h0);
        chk("t7_hold_rst_val", wb_val, 32'h0);
        chk("t7_hold_rst_rd", 32'(wb_rd), 32'h0);
        reset = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/execute_unit_sched.md
Name: execute_unit_sched

Overview:
- Issue/sequence controller between the operand-read stage and the execute stage's multi-cycle functional units (shift unit today; multiply/divide later).
- Accepts one instruction at a time and pulses the start strobe of the selected unit. Stalls upstream while that unit works.
- Captures the unit's result in an output register and hands it to writeback over a valid/ready handshake.
- Owns flush propagation and a watchdog for units that never complete.

Parameters:
- N_UNITS, 2, number of multi-cycle units attached (index 0 = shift unit).
- XLEN, 32, result width.
- TIMEOUT_CYCLES, 15, max BUSY cycles after the start cycle before the op is aborted; must be >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; kills everything held or in flight.
- in_valid  in  1  instruction with operands available.
- in_unit_sel  in  N_UNITS  one-hot target unit.
- in_rd  in  5  destination register index.
- in_ready  out  1  controller accepts the instruction this cycle.
- unit_start  out  N_UNITS  one-hot, single-cycle start; drives the unit's read_valid.
- unit_flush  out  1  broadcast flush to all units.
- unit_valid  in  N_UNITS  per-unit result valid; may be high in the start cycle.
- unit_rd_val  in  N_UNITS*XLEN  per-unit results; unit i at bits [i*XLEN +: XLEN].
- wb_valid  out  1  result held for writeback.
- wb_rd  out  5  destination index of held result.
- wb_val  out  XLEN  held result.
- wb_ready  in  1  writeback consumes the result this cycle.
- err_timeout  out  1  one-cycle pulse when the watchdog aborts an op.
- err_bad_sel  out  1  one-cycle pulse when an accepted instruction has a zero or multi-hot in_unit_sel.

Behaviour:
- States: IDLE, BUSY, HOLD. On reset: state=IDLE; wb_valid=0, wb_rd=0, wb_val=0; err_*=0; watchdog count=0; internal sel/rd registers=0.
- in_ready = !flush && (IDLE || (HOLD && wb_ready)).
- accept = in_valid && in_ready.
- unit_start = accept ? in_unit_sel : 0, combinational. Start is suppressed entirely for a bad select.
- Accept with a valid select:
  - latch sel and rd, clear the watchdog.
  - If unit_valid[sel] is high the same cycle: capture the result, next state HOLD.
  - Otherwise: next state BUSY.
- Accept with a bad select: pulse err_bad_sel next cycle, drop the instruction, next state IDLE. This also applies from HOLD, where the old result has been consumed by wb_ready.
- BUSY:
  - Only unit_valid[latched sel] is observed; other units' valid is ignored.
  - On valid: wb_val <= that unit's slice, wb_rd <= latched rd, next state HOLD.
  - Else the watchdog increments. When it reaches TIMEOUT_CYCLES: assert unit_flush that cycle, pulse err_timeout next cycle, next state IDLE.
- HOLD:
  - wb_valid=1.
  - wb_ready without accept: next state IDLE.
  - wb_ready with accept: start the new op that cycle (back-to-back, no bubble).
  - wb_ready low: hold wb_* stable.
- Latency: a result valid in start cycle T gives wb_valid at T+1. The shift unit with shamt 31 completes at T+3, so wb_valid is at T+4.
- unit_flush = flush || watchdog abort.
- Flush in any state:
  - next state IDLE, wb_valid -> 0 next cycle, the in-flight op is discarded.
  - in_ready=0 and unit_start=0 during the flush cycle.
  - Flush takes priority over unit_valid, wb_ready and timeout in the same cycle; err_timeout is not pulsed.
- Reset mid-operation: immediate return to reset values; unit_start is 0 while reset is asserted.
- wb_valid never drops without wb_ready, except on flush or reset.

Decomposition:
- Shared execute package holds:
  - the state enum {IDLE, BUSY, HOLD};
  - unit index constants (UNIT_SHIFT=0, UNIT_MULDIV=1);
  - the default TIMEOUT_CYCLES.
- One sub-module: execute_sched_watchdog. It is a saturating counter with clear/enable inputs and an expire output, width $clog2(TIMEOUT_CYCLES+1).
- Everything else stays in the top module.

Test Plan:
- Shift unit 0, shamt 3, rs1=0x0000_0001, rd=5:
  - unit_valid in start cycle T, wb_valid at T+1 with wb_val=0x8, wb_rd=5;
  - in_ready low at T+1 until wb_ready.
- SRA shamt 31, rs1=0x8000_0000:
  - BUSY for 3 cycles, wb_val=0xFFFF_FFFF at T+4;
  - in_ready=0 throughout BUSY.
- Back-to-back issue:
  - second instruction offered in HOLD with wb_ready=1 is accepted that cycle and unit_start pulses;
  - wb_ready held low for 4 cycles keeps wb_val/wb_rd stable.
- Stub unit that never asserts valid, TIMEOUT_CYCLES=15:
  - unit_flush pulses at the 15th BUSY cycle;
  - err_timeout pulses the next cycle;
  - state returns to IDLE and the next accept succeeds.
- Flush timing:
  - flush in BUSY two cycles before the unit's valid: no wb_valid ever, unit_flush=1 that cycle, late unit_valid ignored;
  - flush in HOLD: wb_valid drops next cycle.
- in_unit_sel=0 and then 2'b11:
  - both accepted with unit_start=0 and err_bad_sel pulsed;
  - async reset asserted mid-BUSY clears wb_valid and the state immediately.
